// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory controller.
package dmem_pkg;

  localparam int unsigned DMEM_AW = 9;
  localparam int unsigned DMEM_DW = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } dmem_state_e;

  typedef enum logic {
    REQ_CORE = 1'b0,
    REQ_DMA  = 1'b1
  } dmem_owner_e;

  typedef struct packed {
    logic               we;
    logic [2:0]         funct3;
    logic [DMEM_AW-1:0] addr;
    logic [DMEM_DW-1:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_ctrl_if.sv
// Requester-side request/response bundle; one instance per requester.
interface dmem_ctrl_if #(
  parameter int unsigned AW = 9,
  parameter int unsigned DW = 32
);
  logic          req_valid;
  logic          req_ready;
  logic          we;
  logic [2:0]    funct3;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          rsp_valid;
  logic [DW-1:0] rdata;
  logic          err;

  modport master (
    output req_valid, we, funct3, addr, wdata,
    input  req_ready, rsp_valid, rdata, err
  );

  modport slave (
    input  req_valid, we, funct3, addr, wdata,
    output req_ready, rsp_valid, rdata, err
  );
endinterface

// File: rtl/dmem_lane_fmt.sv
// Combinational lane formatter: store byte-enables/replication, load select/extend, fault flags.
// DMEM_MISALIGN_TRAP_EN: flag misaligned halfword/word accesses as faults.
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic               we,
  input  logic [2:0]         funct3,
  input  logic [1:0]         addr_lo,
  input  logic [DMEM_DW-1:0] wdata,
  input  logic [DMEM_DW-1:0] rdata_word,
  output logic [3:0]         be_c,
  output logic [DMEM_DW-1:0] wdata_c,
  output logic [DMEM_DW-1:0] rdata_c,
  output logic               illegal_c,
  output logic               misalign_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Store path: enables follow the addressed lanes, data replicated so any lane is correct.
  always_comb begin
    be_c    = 4'b0000;
    wdata_c = wdata;
    case (funct3)
      F3_B: begin
        be_c    = 4'(4'b0001 << addr_lo);
        wdata_c = {4{wdata[7:0]}};
      end
      F3_H: begin
        be_c    = 4'(4'b0011 << {addr_lo[1], 1'b0});
        wdata_c = {2{wdata[15:0]}};
      end
      F3_W:    be_c = 4'b1111;
      default: be_c = 4'b0000;
    endcase
  end

  always_comb begin
    byte_sel = rdata_word[7:0];
    case (addr_lo)
      2'd0:    byte_sel = rdata_word[7:0];
      2'd1:    byte_sel = rdata_word[15:8];
      2'd2:    byte_sel = rdata_word[23:16];
      default: byte_sel = rdata_word[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata_word[31:16] : rdata_word[15:0];

    rdata_c = '0;
    case (funct3)
      F3_B:    rdata_c = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   rdata_c = {24'h000000, byte_sel};
      F3_H:    rdata_c = {{16{half_sel[15]}}, half_sel};
      F3_HU:   rdata_c = {16'h0000, half_sel};
      F3_W:    rdata_c = rdata_word;
      default: rdata_c = '0;
    endcase
  end

  always_comb begin
    if (we) illegal_c = !(funct3 inside {F3_B, F3_H, F3_W});
    else    illegal_c = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  always_comb begin
    misalign_c = 1'b0;
    if (!illegal_c) begin
      if (funct3[1:0] == 2'b01 && addr_lo[0])      misalign_c = 1'b1;
      if (funct3 == F3_W && addr_lo != 2'b00)      misalign_c = 1'b1;
    end
  end
`else
  assign misalign_c = 1'b0;
`endif

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: round-robin core/DMA arbiter with fixed-latency access sequencer.
// DMEM_MISALIGN_TRAP_EN (in dmem_lane_fmt) turns misaligned half/word accesses into faults.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DM_ADDRESS = DMEM_AW,
  parameter int unsigned DATA_W     = DMEM_DW
) (
  input  logic                  clk,
  input  logic                  reset,
  dmem_ctrl_if.slave            core,
  dmem_ctrl_if.slave            dma,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [3:0]            mem_wr,
  output logic                  mem_rd,
  input  logic [DATA_W-1:0]     mem_rdata
);

  dmem_state_e state_q, state_d;
  dmem_req_t   req_q, req_d, in_req, fmt_req;
  dmem_owner_e owner_q, owner_d, last_q, last_d, sel;
  logic        any_valid;

  logic [DM_ADDRESS-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
  logic [3:0]            mem_wr_q, mem_wr_d;
  logic                  mem_rd_q, mem_rd_d;

  logic              rsp_valid_d, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_d;
  logic              rsp_core, rsp_dma;

  logic              core_rsp_valid_q, core_err_q, dma_rsp_valid_q, dma_err_q;
  logic [DATA_W-1:0] core_rdata_q, dma_rdata_q;

  logic [3:0]        be;
  logic [DATA_W-1:0] lane_wdata, load_data;
  logic              illegal, misalign;

  // Arbitration: on contention the side not granted last wins.
  always_comb begin
    any_valid = core.req_valid | dma.req_valid;
    sel       = REQ_CORE;
    if (core.req_valid && dma.req_valid) sel = (last_q == REQ_CORE) ? REQ_DMA : REQ_CORE;
    else if (dma.req_valid)              sel = REQ_DMA;

    if (sel == REQ_DMA) begin
      in_req.we     = dma.we;
      in_req.funct3 = dma.funct3;
      in_req.addr   = dma.addr;
      in_req.wdata  = dma.wdata;
    end else begin
      in_req.we     = core.we;
      in_req.funct3 = core.funct3;
      in_req.addr   = core.addr;
      in_req.wdata  = core.wdata;
    end
  end

  // Formatter sees the incoming request while granting, the latched one afterwards.
  assign fmt_req = (state_q == S_IDLE) ? in_req : req_q;

  dmem_lane_fmt u_lane_fmt (
    .we         (fmt_req.we),
    .funct3     (fmt_req.funct3),
    .addr_lo    (fmt_req.addr[1:0]),
    .wdata      (fmt_req.wdata),
    .rdata_word (mem_rdata),
    .be_c       (be),
    .wdata_c    (lane_wdata),
    .rdata_c    (load_data),
    .illegal_c  (illegal),
    .misalign_c (misalign)
  );

  // Next-state and next-output decode; registered values become visible in the named state.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    owner_d     = owner_q;
    last_d      = last_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wr_d    = 4'b0000;
    mem_rd_d    = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;

    case (state_q)
      S_IDLE: begin
        if (any_valid) begin
          req_d   = in_req;
          owner_d = sel;
          last_d  = sel;
          if (illegal || misalign) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d    = S_ISSUE;
            mem_addr_d = {in_req.addr[DM_ADDRESS-1:2], 2'b00};
            if (in_req.we) begin
              mem_wr_d    = be;
              mem_wdata_d = lane_wdata;
            end else begin
              mem_rd_d = 1'b1;
            end
          end
        end
      end
      S_ISSUE: begin
        if (req_q.we) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
        end else begin
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = load_data;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign rsp_core = rsp_valid_d && (owner_d == REQ_CORE);
  assign rsp_dma  = rsp_valid_d && (owner_d == REQ_DMA);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_IDLE;
      req_q            <= '0;
      owner_q          <= REQ_CORE;
      last_q           <= REQ_DMA;
      mem_addr_q       <= '0;
      mem_wdata_q      <= '0;
      mem_wr_q         <= 4'b0000;
      mem_rd_q         <= 1'b0;
      core_rsp_valid_q <= 1'b0;
      core_err_q       <= 1'b0;
      core_rdata_q     <= '0;
      dma_rsp_valid_q  <= 1'b0;
      dma_err_q        <= 1'b0;
      dma_rdata_q      <= '0;
    end else begin
      state_q          <= state_d;
      req_q            <= req_d;
      owner_q          <= owner_d;
      last_q           <= last_d;
      mem_addr_q       <= mem_addr_d;
      mem_wdata_q      <= mem_wdata_d;
      mem_wr_q         <= mem_wr_d;
      mem_rd_q         <= mem_rd_d;
      core_rsp_valid_q <= rsp_core;
      core_err_q       <= rsp_core & rsp_err_d;
      core_rdata_q     <= rsp_core ? rsp_rdata_d : '0;
      dma_rsp_valid_q  <= rsp_dma;
      dma_err_q        <= rsp_dma & rsp_err_d;
      dma_rdata_q      <= rsp_dma ? rsp_rdata_d : '0;
    end
  end

  assign core.req_ready = (state_q == S_IDLE) && any_valid && (sel == REQ_CORE);
  assign dma.req_ready  = (state_q == S_IDLE) && any_valid && (sel == REQ_DMA);
  assign core.rsp_valid = core_rsp_valid_q;
  assign core.rdata     = core_rdata_q;
  assign core.err       = core_err_q;
  assign dma.rsp_valid  = dma_rsp_valid_q;
  assign dma.rdata      = dma_rdata_q;
  assign dma.err        = dma_err_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign mem_wr         = mem_wr_q;
  assign mem_rd         = mem_rd_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl with a one-cycle-latency word memory model.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_ctrl_if #(.AW(9), .DW(32)) core_if ();
  dmem_ctrl_if #(.AW(9), .DW(32)) dma_if ();

  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wr;
  logic        mem_rd;
  logic [31:0] mem_rdata;

  dmem_ctrl #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .core      (core_if),
    .dma       (dma_if),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wr    (mem_wr),
    .mem_rd    (mem_rd),
    .mem_rdata (mem_rdata)
  );

  logic [31:0] mem [0:127];

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (mem_wr[b]) mem[mem_addr[8:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    if (mem_rd) mem_rdata <= mem[mem_addr[8:2]];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  logic [31:0] r_rdata, r_wdata;
  logic        r_err, r_rd, r_other;
  logic [3:0]  r_wr;
  logic [8:0]  r_addr;
  int          r_lat;

  task automatic drive(input bit side, input bit v, input bit we, input logic [2:0] f3,
                       input logic [8:0] addr, input logic [31:0] wdata);
    if (side) begin
      dma_if.req_valid = v; dma_if.we = we; dma_if.funct3 = f3;
      dma_if.addr = addr; dma_if.wdata = wdata;
    end else begin
      core_if.req_valid = v; core_if.we = we; core_if.funct3 = f3;
      core_if.addr = addr; core_if.wdata = wdata;
    end
  endtask

  task automatic xact(input string tag, input bit side, input bit we, input logic [2:0] f3,
                      input logic [8:0] addr, input logic [31:0] wdata);
    bit acc = 1'b0;
    bit rdy;
    r_rdata = '0; r_wdata = '0; r_err = 1'b0; r_rd = 1'b0; r_other = 1'b0;
    r_wr = '0; r_addr = '0; r_lat = 0;
    @(negedge clk);
    drive(side, 1'b1, we, f3, addr, wdata);
    for (int i = 0; i < 20; i++) begin
      #1;
      rdy = side ? dma_if.req_ready : core_if.req_ready;
      @(posedge clk);
      if (rdy) begin
        acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
    #1;
    drive(side, 1'b0, 1'b0, 3'b000, 9'h000, 32'h0);
    check_eq({tag, "_accept"}, 32'(acc), 32'd1);
    if (!acc) return;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      r_wr = r_wr | mem_wr;
      if (|mem_wr) begin r_wdata = mem_wdata; r_addr = mem_addr; end
      if (mem_rd)  begin r_rd = 1'b1; r_addr = mem_addr; end
      if (side ? core_if.rsp_valid : dma_if.rsp_valid) r_other = 1'b1;
      if (side ? dma_if.rsp_valid : core_if.rsp_valid) begin
        r_lat   = k;
        r_rdata = side ? dma_if.rdata : core_if.rdata;
        r_err   = side ? dma_if.err : core_if.err;
        break;
      end
    end
  endtask

  task automatic run(input string tag, input bit side, input bit we, input logic [2:0] f3,
                     input logic [8:0] addr, input logic [31:0] wdata, input int exp_lat,
                     input logic [31:0] exp_rdata, input bit exp_err, input logic [3:0] exp_wr,
                     input bit exp_rd);
    xact(tag, side, we, f3, addr, wdata);
    check_eq({tag, "_lat"},   32'(r_lat),   32'(exp_lat));
    check_eq({tag, "_rdata"}, r_rdata,      exp_rdata);
    check_eq({tag, "_err"},   32'(r_err),   32'(exp_err));
    check_eq({tag, "_wr"},    32'(r_wr),    32'(exp_wr));
    check_eq({tag, "_rd"},    32'(r_rd),    32'(exp_rd));
    check_eq({tag, "_other"}, 32'(r_other), 32'd0);
  endtask

  int  gq[$];
  int  rq[$];
  int  exp_seq[3] = '{0, 1, 0};
  int  n_rsp;
  bit  both_rdy, rdy0, got_core, got_dma;
  logic [31:0] core_first, dma_first;

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = '0;
    mem_rdata = '0;
    drive(1'b0, 1'b0, 1'b0, 3'b000, 9'h000, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 3'b000, 9'h000, 32'h0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_mem_wr",    32'(mem_wr),            32'h0);
    check_eq("rst_mem_rd",    32'(mem_rd),            32'h0);
    check_eq("rst_mem_addr",  32'(mem_addr),          32'h0);
    check_eq("rst_mem_wdata", mem_wdata,              32'h0);
    check_eq("rst_core_rsp",  32'(core_if.rsp_valid), 32'h0);
    check_eq("rst_core_rdata", core_if.rdata,         32'h0);
    check_eq("rst_dma_rsp",   32'(dma_if.rsp_valid),  32'h0);
    reset = 1'b0;

    run("sw",  1'b0, 1'b1, F3_W, 9'h010, 32'hDEADBEEF, 2, 32'h0, 1'b0, 4'b1111, 1'b0);
    check_eq("sw_addr", 32'(r_addr), 32'h010);
    check_eq("sw_wdata", r_wdata, 32'hDEADBEEF);
    run("lw",  1'b0, 1'b0, F3_W, 9'h010, 32'h0, 3, 32'hDEADBEEF, 1'b0, 4'b0000, 1'b1);
    check_eq("lw_addr", 32'(r_addr), 32'h010);

    run("sb",  1'b0, 1'b1, F3_B, 9'h013, 32'h000000A5, 2, 32'h0, 1'b0, 4'b1000, 1'b0);
    check_eq("sb_wdata", r_wdata, 32'hA5A5A5A5);
    check_eq("sb_addr", 32'(r_addr), 32'h010);
    run("lb",  1'b0, 1'b0, F3_B,  9'h013, 32'h0, 3, 32'hFFFFFFA5, 1'b0, 4'b0000, 1'b1);
    run("lbu", 1'b0, 1'b0, F3_BU, 9'h013, 32'h0, 3, 32'h000000A5, 1'b0, 4'b0000, 1'b1);

    run("sh",  1'b0, 1'b1, F3_H, 9'h012, 32'h00008001, 2, 32'h0, 1'b0, 4'b1100, 1'b0);
    check_eq("sh_wdata", r_wdata, 32'h80018001);
    run("lh",  1'b0, 1'b0, F3_H,  9'h012, 32'h0, 3, 32'hFFFF8001, 1'b0, 4'b0000, 1'b1);
    run("lhu", 1'b0, 1'b0, F3_HU, 9'h012, 32'h0, 3, 32'h00008001, 1'b0, 4'b0000, 1'b1);
    run("lh_lo", 1'b0, 1'b0, F3_H, 9'h010, 32'h0, 3, 32'hFFFFBEEF, 1'b0, 4'b0000, 1'b1);

`ifdef DMEM_MISALIGN_TRAP_EN
    run("lw_mis", 1'b0, 1'b0, F3_W, 9'h011, 32'h0, 1, 32'h0, 1'b1, 4'b0000, 1'b0);
`else
    run("lw_mis", 1'b0, 1'b0, F3_W, 9'h011, 32'h0, 3, 32'h8001BEEF, 1'b0, 4'b0000, 1'b1);
`endif

    run("ld_ill", 1'b0, 1'b0, 3'b011, 9'h010, 32'h0, 1, 32'h0, 1'b1, 4'b0000, 1'b0);
    run("st_ill", 1'b0, 1'b1, 3'b100, 9'h010, 32'h55, 1, 32'h0, 1'b1, 4'b0000, 1'b0);
    run("dma_lb", 1'b1, 1'b0, F3_B, 9'h010, 32'h0, 3, 32'hFFFFFFEF, 1'b0, 4'b0000, 1'b1);

    // Reset while the store strobe is on the bus: no response may follow.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, F3_W, 9'h020, 32'h12345678);
    #1 rdy0 = core_if.req_ready;
    check_eq("rstiss_ready", 32'(rdy0), 32'd1);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 1'b0, 3'b000, 9'h000, 32'h0);
    @(negedge clk);
    check_eq("rstiss_wr_in_issue", 32'(mem_wr), 32'hF);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("rstiss_mem_wr",    32'(mem_wr),            32'h0);
    check_eq("rstiss_mem_rd",    32'(mem_rd),            32'h0);
    check_eq("rstiss_mem_addr",  32'(mem_addr),          32'h0);
    check_eq("rstiss_mem_wdata", mem_wdata,              32'h0);
    check_eq("rstiss_core_rsp",  32'(core_if.rsp_valid), 32'h0);
    reset = 1'b0;
    n_rsp = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (core_if.rsp_valid || dma_if.rsp_valid) n_rsp++;
    end
    check_eq("rstiss_no_rsp", 32'(n_rsp), 32'd0);
    run("post_rst_lw", 1'b0, 1'b0, F3_W, 9'h010, 32'h0, 3, 32'h8001BEEF, 1'b0, 4'b0000, 1'b1);

    // Both requesters valid continuously from reset.
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 1'b1, 1'b0, F3_W,  9'h010, 32'h0);
    drive(1'b1, 1'b1, 1'b0, F3_BU, 9'h013, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    both_rdy = 1'b0; got_core = 1'b0; got_dma = 1'b0;
    core_first = '0; dma_first = '0;
    for (int i = 0; i < 18; i++) begin
      #1;
      if (core_if.req_ready && dma_if.req_ready) both_rdy = 1'b1;
      if (core_if.req_ready) gq.push_back(0);
      else if (dma_if.req_ready) gq.push_back(1);
      if (core_if.rsp_valid) begin
        rq.push_back(0);
        if (!got_core) begin core_first = core_if.rdata; got_core = 1'b1; end
      end
      if (dma_if.rsp_valid) begin
        rq.push_back(1);
        if (!got_dma) begin dma_first = dma_if.rdata; got_dma = 1'b1; end
      end
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 1'b0, 3'b000, 9'h000, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 3'b000, 9'h000, 32'h0);
    check_eq("rr_both_ready", 32'(both_rdy), 32'd0);
    check_eq("rr_grant_cnt", 32'(gq.size() >= 3), 32'd1);
    check_eq("rr_rsp_cnt",   32'(rq.size() >= 3), 32'd1);
    for (int i = 0; i < 3; i++) begin
      if (gq.size() > i) check_eq($sformatf("rr_grant%0d", i), 32'(gq[i]), 32'(exp_seq[i]));
      if (rq.size() > i) check_eq($sformatf("rr_rsp%0d", i),   32'(rq[i]), 32'(exp_seq[i]));
    end
    check_eq("rr_core_rdata", core_first, 32'h8001BEEF);
    check_eq("rr_dma_rdata",  dma_first,  32'h00000080);

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
